vector_exe_unit: RTL and testbench

- EXE-stage vector ALU. It sits directly downstream of the ID/EXE pipeline register and consumes its operands and EXE control fields.
- It processes one element lane per cycle, so it is a multi-cycle unit. It handshakes upstream (stall) and downstream (to the EXE/MEM register).
- Result, zero flag and a pass-through tag go to the EXE/MEM register.

---
 rtl/vector_exe_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_vector_exe_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_exe_unit.sv
// ---------------------------------------------------------------------------
// vector_exe_unit
//
// EXE-stage vector ALU. Accepts one operation from the ID/EXE register,
// evaluates it one element lane per cycle, then holds the result for the
// EXE/MEM register until it is taken.
//
// Sequence: IDLE (accept) -> RUN (LANES cycles, one lane each) -> DONE (hold).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort; wins over in_valid and out_ready
//   in_valid/in_ready   upstream handshake (in_ready low = stall ID)
//   opcode              lane operation select
//   sel_op              B operand: 0 = VEC2 lane, 1 = scalar broadcast
//   sel_int             scalar source: 0 = sca1, 1 = inmediato
//   VEC1, VEC2          operand vectors (LANES*ELEM_W bits)
//   sca1, inmediato     8-bit scalar sources
//   shift               shift amount, low SH_W bits used
//   tag_in / tag_out    opaque sideband carried with the operation
//   out_valid/out_ready downstream handshake
//   result, zero        vector result and all-lanes-zero flag
//   sat_flag            (VEXE_SAT_EN only) any lane saturated
//
// Configuration macro: VEXE_SAT_EN
//   defined   -> ADD/SUB/MUL saturate unsigned and sat_flag is present
//   undefined -> wrap-around arithmetic, no sat_flag port
// ---------------------------------------------------------------------------
module vector_exe_unit #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int SH_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                opcode,
  input  logic                      sel_op,
  input  logic                      sel_int,
  input  logic [LANES*ELEM_W-1:0]   VEC1,
  input  logic [LANES*ELEM_W-1:0]   VEC2,
  input  logic [7:0]                sca1,
  input  logic [7:0]                inmediato,
  input  logic [7:0]                shift,
  input  logic [7:0]                tag_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ELEM_W-1:0]   result,
  output logic                      zero,
`ifdef VEXE_SAT_EN
  output logic                      sat_flag,
`endif
  output logic [7:0]                tag_out
);

  localparam int VW     = LANES * ELEM_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB  = 4'd1, OP_AND  = 4'd2, OP_OR   = 4'd3,
    OP_XOR  = 4'd4, OP_SHL  = 4'd5, OP_SHR  = 4'd6, OP_MUL  = 4'd7,
    OP_MAXU = 4'd8, OP_MINU = 4'd9
  } op_e;

  state_e              r_state, w_next_state;
  op_e                 r_op;
  logic [VW-1:0]       r_a, r_b, r_result;
  logic [SH_W-1:0]     r_sh;
  logic [LANE_W-1:0]   r_lane;
  logic [7:0]          r_tag;
  logic                r_zero;

  logic [7:0]          w_scalar;
  logic [ELEM_W-1:0]   w_scalar_elem;
  logic [VW-1:0]       w_b_src;
  logic [ELEM_W-1:0]   w_a, w_b, w_lane_res;
  logic [ELEM_W:0]     w_sum, w_diff;
  logic [2*ELEM_W-1:0] w_prod;
  logic [VW-1:0]       w_next_result;
  logic                w_last;

  // -------------------------------------------------------------------------
  // Operand selection at accept time: the scalar is resized to one element
  // (zero-extend or truncate) and replicated across every lane.
  // -------------------------------------------------------------------------
  assign w_scalar      = sel_int ? inmediato : sca1;
  assign w_scalar_elem = ELEM_W'(w_scalar);
  assign w_b_src       = sel_op ? {LANES{w_scalar_elem}} : VEC2;

  // -------------------------------------------------------------------------
  // Lane ALU for the lane currently addressed by r_lane
  // -------------------------------------------------------------------------
  assign w_a    = r_a[r_lane*ELEM_W +: ELEM_W];
  assign w_b    = r_b[r_lane*ELEM_W +: ELEM_W];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};   // MSB set = borrow
  assign w_prod = w_a * w_b;
  assign w_last = (r_lane == LAST_LANE);

`ifdef VEXE_SAT_EN
  logic w_lane_sat;
  logic r_sat;
  assign sat_flag = r_sat;
`endif

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_lane_res = w_a;
`ifdef VEXE_SAT_EN
    w_lane_sat = 1'b0;
`endif
    case (r_op)
`ifdef VEXE_SAT_EN
      OP_ADD: begin
        w_lane_sat = w_sum[ELEM_W];
        w_lane_res = w_sum[ELEM_W] ? '1 : w_sum[ELEM_W-1:0];
      end
      OP_SUB: begin
        w_lane_sat = w_diff[ELEM_W];
        w_lane_res = w_diff[ELEM_W] ? '0 : w_diff[ELEM_W-1:0];
      end
      OP_MUL: begin
        w_lane_sat = |w_prod[2*ELEM_W-1:ELEM_W];
        w_lane_res = w_lane_sat ? '1 : w_prod[ELEM_W-1:0];
      end
`else
      OP_ADD:  w_lane_res = w_sum[ELEM_W-1:0];
      OP_SUB:  w_lane_res = w_diff[ELEM_W-1:0];
      OP_MUL:  w_lane_res = w_prod[ELEM_W-1:0];
`endif
      OP_AND:  w_lane_res = w_a & w_b;
      OP_OR:   w_lane_res = w_a | w_b;
      OP_XOR:  w_lane_res = w_a ^ w_b;
      OP_SHL:  w_lane_res = w_a << r_sh;
      OP_SHR:  w_lane_res = w_a >> r_sh;
      OP_MAXU: w_lane_res = (w_a > w_b) ? w_a : w_b;
      OP_MINU: w_lane_res = (w_a < w_b) ? w_a : w_b;
      default: w_lane_res = w_a;   // opcodes 10-15 pass A through
    endcase
  end

  // Result with the current lane merged in; also feeds the zero flag so it
  // reflects the final lane on the cycle DONE is entered.
  // NOTE: blocking assignments here -- this is combinational, and the second
  // statement must see the value produced by the first.
  always_comb begin
    w_next_result = r_result;
    w_next_result[r_lane*ELEM_W +: ELEM_W] = w_lane_res;
  end

  // Bits that are intentionally not consumed in this configuration.
  logic w_unused;
`ifdef VEXE_SAT_EN
  assign w_unused = ^shift[7:SH_W];
`else
  assign w_unused = ^{shift[7:SH_W], w_sum[ELEM_W], w_diff[ELEM_W],
                      w_prod[2*ELEM_W-1:ELEM_W]};
`endif

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid)  w_next_state = S_RUN;
        S_RUN:   if (w_last)    w_next_state = S_DONE;
        S_DONE:  if (out_ready) w_next_state = S_IDLE;
        default:                w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_sh     <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lane   <= '0;
`ifdef VEXE_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else if (flush) begin
      // Abort: drop the partial result; tag_out keeps its last value.
      r_result <= '0;
      r_zero   <= 1'b0;
      r_lane   <= '0;
`ifdef VEXE_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a      <= VEC1;
          r_b      <= w_b_src;
          r_op     <= op_e'(opcode);
          r_sh     <= shift[SH_W-1:0];
          r_tag    <= tag_in;
          r_result <= '0;
          r_zero   <= 1'b0;
          r_lane   <= '0;
`ifdef VEXE_SAT_EN
          r_sat    <= 1'b0;
`endif
        end
        S_RUN: begin
          r_result <= w_next_result;
          r_lane   <= w_last ? '0 : r_lane + 1'b1;
          if (w_last) r_zero <= (w_next_result == '0);
`ifdef VEXE_SAT_EN
          r_sat    <= r_sat | w_lane_sat;
`endif
        end
        default: ;   // DONE holds everything stable
      endcase
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign tag_out = r_tag;

endmodule

// File: tb/tb_vector_exe_unit.sv
// ---------------------------------------------------------------------------
// Directed testbench for vector_exe_unit (default parameters: 4 x 8-bit).
// Expected values are hand-computed per lane (lane 0 = least significant
// byte). Honours VEXE_SAT_EN to select saturating expectations.
// ---------------------------------------------------------------------------
module tb_vector_exe_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic        sel_op = 1'b0;
  logic        sel_int = 1'b0;
  logic [31:0] VEC1 = '0;
  logic [31:0] VEC2 = '0;
  logic [7:0]  sca1 = '0;
  logic [7:0]  inmediato = '0;
  logic [7:0]  shift = '0;
  logic [7:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic [7:0]  tag_out;
`ifdef VEXE_SAT_EN
  logic        sat_flag;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_exe_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .sel_op(sel_op), .sel_int(sel_int),
    .VEC1(VEC1), .VEC2(VEC2), .sca1(sca1), .inmediato(inmediato),
    .shift(shift), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
`ifdef VEXE_SAT_EN
    .sat_flag(sat_flag),
`endif
    .tag_out(tag_out)
  );

  // Present one operation at posedge+1, accept on the next edge, then count
  // edges until out_valid (bounded). Leaves the DUT in DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] v1,
                        input logic [31:0] v2, input logic so, input logic si,
                        input logic [7:0] s1, input logic [7:0] imm,
                        input logic [7:0] sh, input logic [7:0] tg,
                        output int lat);
    opcode = op; VEC1 = v1; VEC2 = v2; sel_op = so; sel_int = si;
    sca1 = s1; inmediato = imm; shift = sh; tag_in = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero); end
    total++; if (tag_out !== 8'h0) begin bad++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
`ifdef VEXE_SAT_EN
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
`endif
  endtask

  task automatic test_add();
    int lat;
    logic [31:0] exp;
`ifdef VEXE_SAT_EN
    exp = 32'h11FF2334;   // lane 2: 0x02+0xFF clamps
`else
    exp = 32'h11012334;   // lane 2: 0x02+0xFF wraps to 0x01
`endif
    run_op(4'd0, 32'h01020304, 32'h10FF2030, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
    total++; if (result !== exp) begin bad++; $display("FAIL add_result got=%h exp=%h", result, exp); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b exp=0", zero); end
    total++; if (tag_out !== 8'hA5) begin bad++; $display("FAIL add_tag got=%h exp=a5", tag_out); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_in_ready_done got=%b exp=0", in_ready); end
`ifdef VEXE_SAT_EN
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL add_sat got=%b exp=1", sat_flag); end
`endif
    retire();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL add_retire got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_scalar();
    int lat;
    // Immediate broadcast, MUL: 0x0A*3, 0x0B*3, 0x0C*3, 0x0D*3
    run_op(4'd7, 32'h0A0B0C0D, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h55, 8'h03, 8'h00, 8'h3C, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL mul_imm_latency got=%0d exp=4", lat); end
    total++; if (result !== 32'h1E212427) begin bad++; $display("FAIL mul_imm_result got=%h exp=1e212427", result); end
    retire();
    // sca1 broadcast, ADD: +0x10 on every lane
    run_op(4'd0, 32'h01020304, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h10, 8'h77, 8'h00, 8'h3D, lat);
    total++; if (result !== 32'h11121314) begin bad++; $display("FAIL add_sca1_result got=%h exp=11121314", result); end
    total++; if (tag_out !== 8'h3D) begin bad++; $display("FAIL add_sca1_tag got=%h exp=3d", tag_out); end
    retire();
  endtask

  task automatic test_shift_zero();
    int lat;
    run_op(4'd6, 32'h80808080, 32'h0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h0F, 8'h01, lat);
    total++; if (result !== 32'h01010101) begin bad++; $display("FAIL shr_result got=%h exp=01010101", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL shr_zero got=%b exp=0", zero); end
    retire();
    run_op(4'd4, 32'h80808080, 32'h80808080, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, lat);
    total++; if (result !== 32'h0) begin bad++; $display("FAIL xor_result got=%h exp=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL xor_zero got=%b exp=1", zero); end
    retire();
  endtask

  task automatic test_lane_ops();
    logic [3:0]  t_op  [8] = '{4'd8, 4'd9, 4'd2, 4'd3, 4'd12, 4'd1, 4'd7, 4'd5};
    logic [31:0] t_v1  [8] = '{32'h10203040, 32'h10203040, 32'hF0F0FF00, 32'hF0F0FF00,
                               32'h10203040, 32'hF0000010, 32'h10020304, 32'h01020381};
    logic [31:0] t_v2  [8] = '{32'h40302010, 32'h40302010, 32'h3C3C0FF0, 32'h3C3C0FF0,
                               32'hFFFFFFFF, 32'h20000020, 32'h10030405, 32'h00000000};
`ifdef VEXE_SAT_EN
    logic [31:0] t_exp [8] = '{32'h40303040, 32'h10202010, 32'h30300F00, 32'hFCFCFFF0,
                               32'h10203040, 32'hD0000000, 32'hFF060C14, 32'h08101808};
    logic        t_sat [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic [31:0] t_exp [8] = '{32'h40303040, 32'h10202010, 32'h30300F00, 32'hFCFCFFF0,
                               32'h10203040, 32'hD00000F0, 32'h00060C14, 32'h08101808};
`endif
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_v1[i], t_v2[i], 1'b0, 1'b0, 8'h00, 8'h00, 8'hFB, 8'h40 + 8'(i), lat);
      total++; if (result !== t_exp[i]) begin
        bad++; $display("FAIL lane_op[%0d] op=%0d got=%h exp=%h", i, t_op[i], result, t_exp[i]);
      end
      total++; if (tag_out !== 8'h40 + 8'(i)) begin
        bad++; $display("FAIL lane_tag[%0d] got=%h exp=%h", i, tag_out, 8'h40 + 8'(i));
      end
`ifdef VEXE_SAT_EN
      total++; if (sat_flag !== t_sat[i]) begin
        bad++; $display("FAIL lane_sat[%0d] got=%b exp=%b", i, sat_flag, t_sat[i]);
      end
`endif
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(4'd3, 32'h11223344, 32'h00000000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h9C, lat);
    // New request while holding the result: must be ignored
    in_valid = 1'b1; VEC1 = 32'hDEADBEEF; tag_in = 8'h11;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h11223344 || tag_out !== 8'h9C) begin
        bad++;
        $display("FAIL hold_cycle[%0d] got v=%b r=%b res=%h tag=%h exp v=1 r=0 res=11223344 tag=9c",
                 c, out_valid, in_ready, result, tag_out);
      end
    end
    in_valid = 1'b0;
    retire();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int lat;
    // Abort in RUN after lanes 0 and 1 are done (lane counter = 2)
    opcode = 4'd0; VEC1 = 32'h01010101; VEC2 = 32'h01010101; sel_op = 1'b0;
    tag_in = 8'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_run got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    total++; if (lat != 0) begin bad++; $display("FAIL flush_no_pulse got=%0d exp=0", lat); end
    // flush together with in_valid in IDLE: not accepted
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_accept got ready=%b exp=1", in_ready); end
    // flush in DONE drops the held result
    run_op(4'd0, 32'h01020304, 32'h01010101, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, lat);
    flush = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_done got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    // Next operation after flush is correct
    run_op(4'd1, 32'h05060708, 32'h01020304, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h13, lat);
    total++; if (lat != 4 || result !== 32'h04040404) begin
      bad++; $display("FAIL flush_next got lat=%0d res=%h exp lat=4 res=04040404", lat, result);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int lat;
    opcode = 4'd0; VEC1 = 32'h01010101; VEC2 = 32'h02020202; sel_op = 1'b0;
    tag_in = 8'hEE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || tag_out !== 8'h0) begin
      bad++; $display("FAIL reset_mid got r=%b v=%b res=%h tag=%h exp r=1 v=0 res=0 tag=0",
                      in_ready, out_valid, result, tag_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_pulse got=%b exp=0", out_valid); end
    run_op(4'd9, 32'h05FF0A01, 32'h0610090F, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h21, lat);
    total++; if (lat != 4 || result !== 32'h05100901) begin
      bad++; $display("FAIL reset_next got lat=%0d res=%h exp lat=4 res=05100901", lat, result);
    end
    retire();
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_scalar();
    test_shift_zero();
    test_lane_ops();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
